note_lane: RTL and testbench

- Per-player falling-note engine. One instance per lane.
- Spawns a block at the top of the screen and advances it once per video frame.
- Judges the player's button press against the fixed hit bar and accumulates the score.
- Sits directly upstream of the VGA pixel generator: drives one lane's block_top/block_bot and res_top, and feeds the done flag to the winner logic.

---
 rtl/note_lane.sv | 229 ++++++++++++++++++++++
 tb/tb_note_lane.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/note_lane.sv
// note_lane: one lane of the falling-note game.
// A block spawns at the top of the screen, drops SPEED rows per frame_tick_i,
// and is judged against the fixed hit bar when the player presses the button.
// Each hit grows the score bar. Reaching WIN_SCORE raises done_o and parks the lane.
// Optional feature macro: NOTE_LANE_RANDOM_GAP_EN. When it is defined, a 16-bit
// Galois LFSR stretches the spawn gap by 0..15 frames.
module note_lane #(
  parameter int SPEED      = 4,
  parameter int BLOCK_H    = 60,
  parameter int HIT_TOP    = 620,
  parameter int HIT_BOT    = 650,
  parameter int SCREEN_H   = 720,
  parameter int SPAWN_GAP  = 30,
  parameter int SCORE_STEP = 20,
  parameter int RES_BOT    = 720,
  parameter int WIN_SCORE  = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       frame_tick_i,
  input  logic       enable_i,
  input  logic       btn_i,
  output logic [9:0] block_top_o,
  output logic [9:0] block_bot_o,
  output logic [9:0] res_top_o,
  output logic [5:0] score_o,
  output logic       hit_pulse_o,
  output logic       miss_pulse_o,
  output logic       done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    FALL = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] y_pos_q, y_pos_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [5:0]  score_q, score_d;
  logic        done_q, done_d;
  logic        btn_q;
  logic        hit_q, hit_d;
  logic        miss_q, miss_d;
  logic [9:0]  block_top_q, block_bot_q, res_top_q;

  logic        press_s;
  logic [10:0] cur_bot_raw_s, cur_bot_s;
  logic [10:0] nxt_bot_raw_s, nxt_bot_s;
  logic [10:0] y_step_s;
  logic        in_win_s;
  logic [5:0]  score_inc_s;
  logic        win_s;
  logic [7:0]  gap_len_s;
  logic [10:0] res_d_s;
  logic        enter_gap_s;

  // A press is the rising edge of the registered button level.
  assign press_s = btn_i & ~btn_q;

  // Geometry of the block at its current (pre-move) position.
  assign cur_bot_raw_s = y_pos_q + 11'(BLOCK_H);
  assign cur_bot_s     = (cur_bot_raw_s > 11'(SCREEN_H)) ? 11'(SCREEN_H) : cur_bot_raw_s;
  assign in_win_s      = (cur_bot_s > 11'(HIT_TOP)) && (y_pos_q < 11'(HIT_BOT));
  assign y_step_s      = y_pos_q + 11'(SPEED);

  // Geometry of the block at the position it will hold after this edge.
  assign nxt_bot_raw_s = y_pos_d + 11'(BLOCK_H);
  assign nxt_bot_s     = (nxt_bot_raw_s > 11'(SCREEN_H)) ? 11'(SCREEN_H) : nxt_bot_raw_s;

  // Saturating score increment and the win condition it implies.
  assign score_inc_s = (score_q == 6'(WIN_SCORE)) ? score_q : score_q + 6'd1;
  assign win_s       = (score_inc_s == 6'(WIN_SCORE));

  // Score bar top is computed wide, then truncated on the output register.
  assign res_d_s = 11'(RES_BOT) - (11'(score_d) * 11'(SCORE_STEP));

  assign enter_gap_s = (state_d == GAP) && (state_q != GAP);

`ifdef NOTE_LANE_RANDOM_GAP_EN
  logic [15:0] lfsr_q;
  logic [7:0]  gap_lim_q, gap_lim_d;

  // Galois LFSR (taps 16,14,13,11) stepped once per frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= 16'hACE1;
    end else if (frame_tick_i) begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end else begin
      lfsr_q <= lfsr_q;
    end
  end

  // Gap length is sampled once, when the lane enters GAP.
  always_comb begin
    gap_lim_d = gap_lim_q;
    if (enter_gap_s) begin
      gap_lim_d = 8'(SPAWN_GAP) + {4'd0, lfsr_q[3:0]};
    end else begin
      gap_lim_d = gap_lim_q;
    end
  end

  // Latched gap length register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gap_lim_q <= 8'(SPAWN_GAP);
    end else begin
      gap_lim_q <= gap_lim_d;
    end
  end

  assign gap_len_s = gap_lim_q;
`else
  assign gap_len_s = 8'(SPAWN_GAP);
`endif

  // Next-state logic: enable gating, gap counting, falling and judging.
  always_comb begin
    state_d   = state_q;
    y_pos_d   = y_pos_q;
    gap_cnt_d = gap_cnt_q;
    score_d   = score_q;
    done_d    = done_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    if (!enable_i) begin
      state_d   = IDLE;
      gap_cnt_d = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          gap_cnt_d = 8'd0;
          if (!done_q) begin
            state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end
        GAP: begin
          if (frame_tick_i) begin
            if (gap_cnt_q == gap_len_s - 8'd1) begin
              state_d   = FALL;
              y_pos_d   = 11'd0;
              gap_cnt_d = 8'd0;
            end else begin
              gap_cnt_d = gap_cnt_q + 8'd1;
            end
          end else begin
            gap_cnt_d = gap_cnt_q;
          end
        end
        FALL: begin
          if (press_s) begin
            gap_cnt_d = 8'd0;
            if (in_win_s) begin
              hit_d   = 1'b1;
              score_d = score_inc_s;
              if (win_s) begin
                done_d  = 1'b1;
                state_d = IDLE;
              end else begin
                state_d = GAP;
              end
            end else begin
              miss_d  = 1'b1;
              state_d = GAP;
            end
          end else if (frame_tick_i) begin
            y_pos_d = y_step_s;
            if (y_step_s >= 11'(SCREEN_H)) begin
              miss_d    = 1'b1;
              state_d   = GAP;
              gap_cnt_d = 8'd0;
            end else begin
              state_d = FALL;
            end
          end else begin
            state_d = FALL;
          end
        end
        default: begin
          state_d   = IDLE;
          gap_cnt_d = 8'd0;
        end
      endcase
    end
  end

  // State, position, counters and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      y_pos_q     <= 11'd0;
      gap_cnt_q   <= 8'd0;
      score_q     <= 6'd0;
      done_q      <= 1'b0;
      btn_q       <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      block_top_q <= 10'd0;
      block_bot_q <= 10'd0;
      res_top_q   <= 10'(RES_BOT);
    end else begin
      state_q     <= state_d;
      y_pos_q     <= y_pos_d;
      gap_cnt_q   <= gap_cnt_d;
      score_q     <= score_d;
      done_q      <= done_d;
      btn_q       <= btn_i;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      block_top_q <= (state_d == FALL) ? y_pos_d[9:0] : 10'd0;
      block_bot_q <= (state_d == FALL) ? nxt_bot_s[9:0] : 10'd0;
      res_top_q   <= res_d_s[9:0];
    end
  end

  assign block_top_o  = block_top_q;
  assign block_bot_o  = block_bot_q;
  assign res_top_o    = res_top_q;
  assign score_o      = score_q;
  assign hit_pulse_o  = hit_q;
  assign miss_pulse_o = miss_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_note_lane.sv
// Bench for note_lane: a table of frame sequences with hand-computed
// expectations, hand-written multi-cycle corner cases, then random stimulus.
// Every cycle is also compared against a behavioural model of the lane.
module tb_note_lane;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       frame_tick_i = 1'b0;
  logic       enable_i = 1'b0;
  logic       btn_i = 1'b0;
  logic [9:0] block_top_o, block_bot_o, res_top_o;
  logic [5:0] score_o;
  logic       hit_pulse_o, miss_pulse_o, done_o;

  int n_checks = 0;
  int n_fail   = 0;

  note_lane dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .frame_tick_i (frame_tick_i),
    .enable_i     (enable_i),
    .btn_i        (btn_i),
    .block_top_o  (block_top_o),
    .block_bot_o  (block_bot_o),
    .res_top_o    (res_top_o),
    .score_o      (score_o),
    .hit_pulse_o  (hit_pulse_o),
    .miss_pulse_o (miss_pulse_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0;
  localparam int M_GAP  = 1;
  localparam int M_FALL = 2;

  int m_mode = M_IDLE, m_y = 0, m_ticks = 0, m_score = 0;
  bit m_done = 0, m_hit = 0, m_miss = 0, m_pb = 0;

  function automatic int bot_of(input int y);
    return (y + 60 > 720) ? 720 : y + 60;
  endfunction

  task automatic model_step(input bit r, input bit e, input bit t, input bit b);
    bit press;
    if (r) begin
      m_mode = M_IDLE; m_y = 0; m_ticks = 0; m_score = 0;
      m_done = 0; m_hit = 0; m_miss = 0; m_pb = 0;
    end else begin
      press  = b && !m_pb;
      m_pb   = b;
      m_hit  = 0;
      m_miss = 0;
      if (!e) begin
        m_mode = M_IDLE;
      end else if (m_mode == M_IDLE) begin
        if (!m_done) begin m_mode = M_GAP; m_ticks = 0; end
      end else if (m_mode == M_GAP) begin
        if (t) begin
          m_ticks++;
          if (m_ticks == 30) begin m_mode = M_FALL; m_y = 0; end
        end
      end else begin
        if (press) begin
          if (bot_of(m_y) > 620 && m_y < 650) begin
            m_hit = 1;
            if (m_score < 32) m_score++;
            if (m_score == 32) begin m_done = 1; m_mode = M_IDLE; end
            else begin m_mode = M_GAP; m_ticks = 0; end
          end else begin
            m_miss = 1; m_mode = M_GAP; m_ticks = 0;
          end
        end else if (t) begin
          m_y += 4;
          if (m_y >= 720) begin m_miss = 1; m_mode = M_GAP; m_ticks = 0; end
        end
      end
    end
  endtask

  function automatic logic [38:0] model_vec();
    int top, bot;
    top = (m_mode == M_FALL) ? m_y : 0;
    bot = (m_mode == M_FALL) ? bot_of(m_y) : 0;
    return {10'(top), 10'(bot), 10'(720 - 20 * m_score), 6'(m_score), m_hit, m_miss, m_done};
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [38:0] act, input logic [38:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic step(input bit b, input bit t, input bit e, input bit r);
    @(negedge clk);
    btn_i = b; frame_tick_i = t; enable_i = e; rst_i = r;
    model_step(r, e, t, b);
    @(posedge clk);
    #1;
    check("cycle_vs_model",
          {block_top_o, block_bot_o, res_top_o, score_o, hit_pulse_o, miss_pulse_o, done_o},
          model_vec());
  endtask

  // Advance frames until the model shows the block falling at row y.
  task automatic run_to(input int y);
    int k;
    for (k = 0; k < 1000; k++) begin
      if (m_mode == M_FALL && m_y == y) break;
      step(0, 0, 1, 0);
      step(0, 1, 1, 0);
    end
    if (k == 1000) begin
      n_checks++; n_fail++;
      $display("FAIL run_to: block never reached row %0d", y);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         ticks;
    bit         en;
    int         pk;     // 0 none, 1 press, 2 press together with frame_tick
    logic [9:0] top, bot, res;
    logic [5:0] sc;
    logic       hit, miss, done;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int hits, misses;

    tbl[0]  = '{10,  1'b0, 0, 10'd0,   10'd0,   10'd720, 6'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{30,  1'b1, 0, 10'd0,   10'd60,  10'd720, 6'd0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{141, 1'b1, 0, 10'd564, 10'd624, 10'd720, 6'd0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{0,   1'b1, 1, 10'd0,   10'd0,   10'd700, 6'd1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{30,  1'b1, 0, 10'd0,   10'd60,  10'd700, 6'd1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{100, 1'b1, 0, 10'd400, 10'd460, 10'd700, 6'd1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{0,   1'b1, 1, 10'd0,   10'd0,   10'd700, 6'd1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{30,  1'b1, 0, 10'd0,   10'd60,  10'd700, 6'd1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{162, 1'b1, 0, 10'd648, 10'd708, 10'd700, 6'd1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{0,   1'b1, 2, 10'd0,   10'd0,   10'd680, 6'd2, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{30,  1'b1, 0, 10'd0,   10'd60,  10'd680, 6'd2, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{179, 1'b1, 0, 10'd716, 10'd720, 10'd680, 6'd2, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1,   1'b1, 0, 10'd0,   10'd0,   10'd680, 6'd2, 1'b0, 1'b1, 1'b0};

    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    for (int i = 0; i < 13; i++) begin
      step(0, 0, tbl[i].en, 0);
      for (int k = 0; k < tbl[i].ticks; k++) begin
        step(0, 0, tbl[i].en, 0);
        step(0, 1, tbl[i].en, 0);
      end
      if (tbl[i].pk == 1) step(1, 0, tbl[i].en, 0);
      else if (tbl[i].pk == 2) step(1, 1, tbl[i].en, 0);
      check($sformatf("vec%0d_top", i),   39'(block_top_o),  39'(tbl[i].top));
      check($sformatf("vec%0d_bot", i),   39'(block_bot_o),  39'(tbl[i].bot));
      check($sformatf("vec%0d_res", i),   39'(res_top_o),    39'(tbl[i].res));
      check($sformatf("vec%0d_score", i), 39'(score_o),      39'(tbl[i].sc));
      check($sformatf("vec%0d_hit", i),   39'(hit_pulse_o),  39'(tbl[i].hit));
      check($sformatf("vec%0d_miss", i),  39'(miss_pulse_o), 39'(tbl[i].miss));
      check($sformatf("vec%0d_done", i),  39'(done_o),       39'(tbl[i].done));
    end

    // Held button: exactly one press over a long hold.
    run_to(564);
    hits = 0; misses = 0;
    for (int k = 0; k < 20; k++) begin
      step(1, 1, 1, 0);
      hits += int'(hit_pulse_o); misses += int'(miss_pulse_o);
      step(1, 0, 1, 0);
      hits += int'(hit_pulse_o); misses += int'(miss_pulse_o);
    end
    step(0, 0, 1, 0);
    check("held_btn_hits", 39'(hits), 39'd1);
    check("held_btn_misses", 39'(misses), 39'd0);
    check("held_btn_score", 39'(score_o), 39'd3);

    // Enable low mid-fall hides the block with no pulse and keeps the score.
    run_to(200);
    step(0, 0, 0, 0);
    check("enable_low_top", 39'(block_top_o), 39'd0);
    check("enable_low_miss", 39'(miss_pulse_o), 39'd0);
    check("enable_low_score", 39'(score_o), 39'd3);

    // Play hits until the lane wins.
    for (int k = 0; k < 40 && !m_done; k++) begin
      run_to(564);
      step(1, 0, 1, 0);
      step(0, 0, 1, 0);
    end
    check("win_done", 39'(done_o), 39'd1);
    check("win_score", 39'(score_o), 39'd32);
    check("win_res_top", 39'(res_top_o), 39'd80);

    // Once done, the lane stays parked: no spawn, no pulses.
    hits = 0; misses = 0;
    for (int k = 0; k < 40; k++) begin
      step(1, 1, 1, 0);
      hits += int'(hit_pulse_o) + int'(miss_pulse_o) + int'(block_top_o != 10'd0);
      step(0, 0, 1, 0);
      hits += int'(hit_pulse_o) + int'(miss_pulse_o) + int'(block_bot_o != 10'd0);
    end
    check("done_parked", 39'(hits), 39'd0);
    check("done_held", 39'(done_o), 39'd1);

    // Reset mid-fall returns every output to its reset value.
    step(0, 0, 1, 1);
    run_to(300);
    check("pre_rst_top", 39'(block_top_o), 39'd300);
    step(0, 0, 1, 1);
    check("rst_midfall",
          {block_top_o, block_bot_o, res_top_o, score_o, hit_pulse_o, miss_pulse_o, done_o},
          {10'd0, 10'd0, 10'd720, 6'd0, 1'b0, 1'b0, 1'b0});

    // Random stimulus against the model.
    begin
      bit b = 0;
      for (int k = 0; k < 6000; k++) begin
        if ($urandom_range(7, 0) == 0) b = ~b;
        step(b, ($urandom_range(2, 0) == 0), ($urandom_range(59, 0) != 0),
             ($urandom_range(799, 0) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
